// File: rtl/apb_to_axil_bridge.sv
// APB3 slave to AXI4-Lite master bridge: one outstanding transfer at a time,
// full-word writes, AXI responses mapped onto PSLVERR.
module apb_to_axil_bridge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t state;
  state_t state_next;
  logic   aborted;
  logic   aborted_next;
  logic   setup;
  logic   complete;
  logic   unused_resp_lsb;

  // Only bit 1 of an AXI response distinguishes error from success.
  assign unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

  always_comb begin
    state_next   = state;
    setup        = (state == IDLE) && PSEL && !PENABLE;
    aborted_next = 1'b0;
    // A master that drops PSEL mid-transfer gets no PREADY; the AXI side still drains.
    if (state != IDLE) aborted_next = aborted || !PSEL;
    case (state)
      IDLE:    if (setup) state_next = PWRITE ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) state_next = WR_RESP;
      WR_RESP: if (m_bvalid && m_bready) state_next = DONE;
      RD_REQ:  if (m_arvalid && m_arready) state_next = RD_RESP;
      RD_RESP: if (m_rvalid && m_rready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    complete = (state_next == DONE) && (state != DONE) && !aborted_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aborted   <= 1'b0;
      m_awaddr  <= '0;
      m_araddr  <= '0;
      m_wdata   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
      m_bready  <= 1'b0;
      m_rready  <= 1'b0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      state   <= state_next;
      aborted <= aborted_next;
      if (setup) begin
        m_awaddr <= PADDR;
        m_araddr <= PADDR;
        m_wdata  <= PWDATA;
      end
      // Each valid falls on its own handshake, so AW and W may complete in either order.
      m_awvalid <= (setup && PWRITE) || (m_awvalid && !m_awready);
      m_wvalid  <= (setup && PWRITE) || (m_wvalid && !m_wready);
      m_arvalid <= (setup && !PWRITE) || (m_arvalid && !m_arready);
      m_bready  <= (state_next == WR_RESP);
      m_rready  <= (state_next == RD_RESP);
      // APB completion outputs are loaded on the edge that enters DONE and cleared on the next.
      PREADY  <= complete;
      PSLVERR <= complete && ((state == WR_RESP) ? m_bresp[1] : m_rresp[1]);
      PRDATA  <= (complete && (state == RD_RESP)) ? m_rdata : '0;
    end
  end

endmodule

// File: doc/apb_to_axil_bridge.md
APB_TO_AXIL_BRIDGE -- requirements
Module: apb_to_axil_bridge

Interface
REQ-001 SHALL have port clk, in, 1: clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, in, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port PSEL, in, 1: APB slave select.
REQ-004 SHALL have port PENABLE, in, 1: APB access phase.
REQ-005 SHALL have port PWRITE, in, 1: 1 = write, 0 = read.
REQ-006 SHALL have port PADDR, in, 32: APB address.
REQ-007 SHALL have port PWDATA, in, 32: APB write data.
REQ-008 SHALL have port PRDATA, out, 32: APB read data.
REQ-009 SHALL have port PREADY, out, 1: transfer complete.
REQ-010 SHALL have port PSLVERR, out, 1: transfer error.
REQ-011 SHALL have port m_awaddr/m_awvalid, out, 32/1; and m_awready, in, 1: AXI4-Lite write-address channel.
REQ-012 SHALL have port m_wdata/m_wvalid, out, 32/1; and m_wready, in, 1: write-data channel. Writes are always full-word; there is no strobe.
REQ-013 SHALL have port m_bresp, in, 2; m_bvalid, in, 1; and m_bready, out, 1: write-response channel.
REQ-014 SHALL have port m_araddr/m_arvalid, out, 32/1; and m_arready, in, 1: read-address channel.
REQ-015 SHALL have port m_rdata, in, 32; m_rresp, in, 2; m_rvalid, in, 1; and m_rready, out, 1: read-data channel.

Function
REQ-016 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-017 In IDLE, when PSEL=1 and PENABLE=0 are sampled, the bridge SHALL:
- latch PADDR, PWDATA and PWRITE;
- go to WR_REQ (write) or RD_REQ (read);
- assert m_awvalid and m_wvalid together (write), or m_arvalid (read), from the next cycle.
REQ-018 In WR_REQ, m_awvalid and m_wvalid SHALL each deassert on their own handshake edge; same-edge or either-order handshakes SHALL be supported; the FSM SHALL go to WR_RESP when both have completed.
REQ-019 In WR_RESP, m_bready=1; on m_bvalid, the bridge SHALL capture err=m_bresp[1] and go to DONE.
REQ-020 In RD_REQ, m_arvalid SHALL be held until m_arready, then the FSM SHALL go to RD_RESP.
REQ-021 In RD_RESP, m_rready=1; on m_rvalid, the bridge SHALL capture m_rdata and err=m_rresp[1] and go to DONE.
REQ-022 Any AXI valid, once asserted, SHALL remain stable with its address/data until handshake; the bridge SHALL never withdraw a valid.
REQ-023 In DONE, PREADY=1 for exactly one cycle, with:
- PSLVERR=err;
- PRDATA = captured data (reads) or 0 (writes);
then the FSM SHALL return to IDLE.
REQ-024 Outside DONE, PREADY=0, PSLVERR=0 and PRDATA=0; all outputs SHALL be registered.
REQ-025 Minimum latency with all AXI readies/valids already high: the APB transfer SHALL complete with 2 wait states (PREADY high in the 3rd cycle after the setup phase).
REQ-026 Back-to-back transfers: a setup phase in the cycle after DONE SHALL be accepted with no idle penalty.
REQ-027 If PSEL drops before DONE (APB protocol violation), the bridge SHALL finish the AXI transaction, suppress PREADY, and return to IDLE.
REQ-028 Setup phases arriving while not in IDLE SHALL be ignored; m_bvalid/m_rvalid arriving outside WR_RESP/RD_RESP SHALL be ignored.
REQ-029 Response mapping: OKAY/EXOKAY SHALL give PSLVERR=0; SLVERR/DECERR SHALL give PSLVERR=1.

Reset
REQ-030 While rst_n=0, the bridge SHALL be in state IDLE with all outputs and latches at 0, including mid-transaction; outstanding AXI transfers SHALL be abandoned because both sides share the reset.

Verification
REQ-031 Write 0x1000 <- 0xDEADBEEF, all readies=1, bvalid the edge after AW/W handshake, bresp=00 -> AW/W carry 0x1000/0xDEADBEEF; PREADY=1 3rd cycle after setup; PSLVERR=0.
REQ-032 Read 0x2004, arready delayed 3 cycles, rdata=0x12345678 with rresp=10 -> arvalid held 3 cycles; PRDATA=0x12345678 and PSLVERR=1 during the single PREADY cycle.
REQ-033 Write with wready 2 cycles before awready, then awready 2 cycles before wready -> each valid drops independently on its own handshake; exactly one B accepted.
REQ-034 Back-to-back write then read, zero-latency AXI -> the read setup in the cycle after DONE is accepted; AR issued one cycle after.
REQ-035 rst_n pulsed low while in RD_RESP -> all outputs 0 asynchronously; the next setup phase completes normally.
REQ-036 PSEL dropped during WR_RESP -> B is still accepted; no PREADY pulse; FSM returns to IDLE.
